// File: rtl/lcd_pkg.sv
// Purpose: shared constants, state types and step-decoding helpers for the HD44780 refresh controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lcd_pkg;

    // HD44780 command bytes used by the init and refresh sequences
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'hC0;

    // Step pointer landmarks: 0..3 init, 4 line-1 address, 5..20 line-1 chars,
    // 21 line-2 address, 22..37 line-2 chars
    localparam logic [5:0] STEP_INIT_LAST = 6'd3;
    localparam logic [5:0] STEP_LINE1     = 6'd4;
    localparam logic [5:0] STEP_LINE2     = 6'd21;
    localparam logic [5:0] STEP_LAST      = 6'd37;

    typedef enum logic [1:0] {
        ST_PWR_WAIT,
        ST_LOAD_IDX,
        ST_LOAD_DAT,
        ST_STROBE
    } ctrl_state_e;

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_SETUP,
        BS_PULSE,
        BS_HOLD,
        BS_EXEC_WAIT
    } strobe_state_e;

    function automatic logic step_is_data(input logic [5:0] step);
        return (step > STEP_LINE1) && (step != STEP_LINE2);
    endfunction

    function automatic logic [4:0] step_index(input logic [5:0] step);
        return (step < STEP_LINE2) ? 5'(step - 6'd5) : 5'(step - 6'd6);
    endfunction

    function automatic logic [7:0] step_cmd(input logic [5:0] step);
        case (step)
            6'd0:       return CMD_FUNC_8B2L;
            6'd1:       return CMD_DISP_ON;
            6'd2:       return CMD_CLEAR;
            6'd3:       return CMD_ENTRY_INC;
            STEP_LINE2: return CMD_LINE2;
            default:    return CMD_LINE1;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_strobe.sv
// Purpose: latches one byte/RS and runs the SETUP -> EN PULSE -> HOLD -> EXEC_WAIT bus cycle.
// Latency: done_o pulses T_SETUP+T_PULSE+T_HOLD+T_wait clocks after start_i.
// Backpressure: start_i is ignored while a cycle is in progress; caller waits for done_o.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/byte_i/rs_i load a byte;
//        en_o/rs_o/data_o drive the LCD bus; done_o marks the last EXEC_WAIT clock.
module lcd_bus_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 16,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2500,
    parameter int unsigned T_CLEAR = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       rs_i,
    output logic       en_o,
    output logic       rs_o,
    output logic [7:0] data_o,
    output logic       done_o
);

    localparam int unsigned M1    = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int unsigned M2    = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int unsigned M3    = (M2 > T_EXEC) ? M2 : T_EXEC;
    localparam int unsigned T_MAX = (M3 > T_CLEAR) ? M3 : T_CLEAR;
    // counter runs 0..T-1 inside a state
    localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    strobe_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          clr_q, clr_d;
    logic          en_q, en_d;
    logic [31:0]   lim;
    logic          last;

    always_comb begin
        case (state_q)
            BS_SETUP:     lim = T_SETUP;
            BS_PULSE:     lim = T_PULSE;
            BS_HOLD:      lim = T_HOLD;
            BS_EXEC_WAIT: lim = clr_q ? T_CLEAR : T_EXEC;
            default:      lim = 32'd0;
        endcase
        last    = (32'(cnt_q) + 32'd1) >= lim;

        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        data_d  = data_q;
        rs_d    = rs_q;
        clr_d   = clr_q;
        done_o  = 1'b0;

        case (state_q)
            BS_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = BS_SETUP;
                    data_d  = byte_i;
                    rs_d    = rs_i;
                    // only the clear command (not a CGRAM char 0x01) needs the long wait
                    clr_d   = !rs_i && (byte_i == CMD_CLEAR);
                end
            end
            BS_SETUP: if (last) begin
                state_d = BS_PULSE;
                cnt_d   = '0;
            end
            BS_PULSE: if (last) begin
                state_d = BS_HOLD;
                cnt_d   = '0;
            end
            BS_HOLD: if (last) begin
                state_d = BS_EXEC_WAIT;
                cnt_d   = '0;
            end
            BS_EXEC_WAIT: if (last) begin
                state_d = BS_IDLE;
                cnt_d   = '0;
                done_o  = 1'b1;
            end
            default: begin
                state_d = BS_IDLE;
                cnt_d   = '0;
            end
        endcase

        en_d = (state_d == BS_PULSE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BS_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
        end
    end

    assign en_o   = en_q;
    assign rs_o   = rs_q;
    assign data_o = data_q;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Purpose: powers up a 16x2 HD44780, runs its init, then refreshes 32 chars from lcd_index/lcd_char forever.
// Latency: per byte 2+T_SETUP+T_PULSE+T_HOLD+T_wait clocks; first EN rise T_PWR+2+T_SETUP after reset.
// Backpressure: none; the character source must answer within one clock of lcd_index changing.
// Ports: CLOCK_50/reset_n; lcd_char in, lcd_index out; init_done level, frame_done pulse;
//        LCD_* pins (LCD_DATA always driven since RW is tied low).
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 16,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2500,
    parameter int unsigned T_CLEAR = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] lcd_char,
    output logic [4:0] lcd_index,
    output logic       init_done,
    output logic       frame_done,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    inout  wire  [7:0] LCD_DATA
);

    localparam int unsigned PW = (T_PWR > 1) ? $clog2(T_PWR) : 1;

    ctrl_state_e state_q, state_d;
    logic [5:0]  step_q, step_d;
    logic [4:0]  idx_q, idx_d;
    logic        init_q, init_d;
    logic        frame_q, frame_d;
    logic [PW-1:0] pcnt_q, pcnt_d;

    logic        start_w, done_w, rs_w;
    logic [7:0]  byte_w, data_w;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        idx_d   = idx_q;
        init_d  = init_q;
        frame_d = 1'b0;
        pcnt_d  = '0;
        start_w = 1'b0;
        rs_w    = step_is_data(step_q);
        byte_w  = rs_w ? lcd_char : step_cmd(step_q);

        case (state_q)
            ST_PWR_WAIT: begin
                pcnt_d = pcnt_q + PW'(1);
                if ((32'(pcnt_q) + 32'd1) >= T_PWR) begin
                    state_d = ST_LOAD_IDX;
                    pcnt_d  = '0;
                end
            end
            ST_LOAD_IDX: state_d = ST_LOAD_DAT;
            ST_LOAD_DAT: begin
                start_w = 1'b1;
                state_d = ST_STROBE;
            end
            ST_STROBE: if (done_w) begin
                state_d = ST_LOAD_IDX;
                if (step_q == STEP_INIT_LAST) init_d = 1'b1;
                if (step_q == STEP_LAST) begin
                    step_d  = STEP_LINE1;
                    frame_d = 1'b1;
                end else begin
                    step_d  = step_q + 6'd1;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase

        // Index is updated on LOAD entry so a registered source has one clock
        // before lcd_char is captured at the end of the second LOAD cycle.
        if (state_d == ST_LOAD_IDX && step_is_data(step_d)) idx_d = step_index(step_d);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PWR_WAIT;
            step_q  <= 6'd0;
            idx_q   <= 5'd0;
            init_q  <= 1'b0;
            frame_q <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            init_q  <= init_d;
            frame_q <= frame_d;
            pcnt_q  <= pcnt_d;
        end
    end

    lcd_bus_strobe #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_EXEC  (T_EXEC),
        .T_CLEAR (T_CLEAR)
    ) u_strobe (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .start_i (start_w),
        .byte_i  (byte_w),
        .rs_i    (rs_w),
        .en_o    (LCD_EN),
        .rs_o    (LCD_RS),
        .data_o  (data_w),
        .done_o  (done_w)
    );

    assign LCD_DATA   = data_w;
    assign lcd_index  = idx_q;
    assign init_done  = init_q;
    assign frame_done = frame_q;
    assign LCD_ON     = 1'b1;
    assign LCD_BLON   = 1'b1;
    assign LCD_RW     = 1'b0;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Purpose: randomized bench for lcd_refresh_ctrl against a stream-position reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lcd_refresh_ctrl;

    localparam int unsigned T_PWR   = 10;
    localparam int unsigned T_SETUP = 2;
    localparam int unsigned T_PULSE = 4;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned T_EXEC  = 8;
    localparam int unsigned T_CLEAR = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] lcd_char;
    logic [4:0] lcd_index;
    logic       init_done, frame_done;
    logic       lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs;
    wire  [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(
        .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
    ) dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .lcd_char   (lcd_char),
        .lcd_index  (lcd_index),
        .init_done  (init_done),
        .frame_done (frame_done),
        .LCD_ON     (lcd_on),
        .LCD_BLON   (lcd_blon),
        .LCD_RW     (lcd_rw),
        .LCD_EN     (lcd_en),
        .LCD_RS     (lcd_rs),
        .LCD_DATA   (lcd_data)
    );

    // Character source: combinational or one-cycle registered lookup
    logic [7:0] tbl [32];
    logic [7:0] char_reg;
    logic       src_reg;
    always @(posedge clk) char_reg <= tbl[lcd_index];
    assign lcd_char = src_reg ? char_reg : tbl[lcd_index];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {RS,DATA} of the pos-th EN strobe since reset
    function automatic logic [8:0] exp_byte(input int pos);
        int p;
        if (pos < 4) begin
            case (pos)
                0:       return 9'h038;
                1:       return 9'h00C;
                2:       return 9'h001;
                default: return 9'h006;
            endcase
        end
        p = (pos - 4) % 34;
        if (p == 0)  return 9'h080;
        if (p <= 16) return {1'b1, tbl[p-1]};
        if (p == 17) return 9'h0C0;
        return {1'b1, tbl[p-2]};
    endfunction

    function automatic int exp_index(input int pos);
        int p;
        p = (pos - 4) % 34;
        return (p <= 16) ? p - 1 : p - 2;
    endfunction

    // Monitor state
    int         cyc, npos, frames_seen, last_rise, hold_left, fd_rise;
    logic       en_prev, fd_prev, init_prev, watch, stab_bad, last_clear;
    logic [8:0] cap, e;

    always @(negedge clk) begin
        if (!reset_n) begin
            cyc = 0; npos = 0; frames_seen = 0; last_rise = 0; hold_left = 0; fd_rise = 0;
            en_prev = 1'b0; fd_prev = 1'b0; init_prev = 1'b0; watch = 1'b0;
            stab_bad = 1'b0; last_clear = 1'b0;
        end else begin
            cyc++;
            if (lcd_en && !en_prev) begin
                cap = {lcd_rs, lcd_data};
                e   = exp_byte(npos);
                check_eq("byte", 32'(cap), 32'(e));
                if (npos == 0)
                    check_eq("first_rise", cyc, T_PWR + 2 + T_SETUP);
                else
                    check_eq("gap", cyc - last_rise,
                             2 + T_SETUP + T_PULSE + T_HOLD + (last_clear ? T_CLEAR : T_EXEC));
                check_eq("init_done_lvl", 32'(init_done), 32'(npos >= 4));
                if (e[8]) check_eq("index", 32'(lcd_index), exp_index(npos));
                if (npos > 4 && (npos - 4) % 34 == 0)
                    check_eq("frame_count", frames_seen, (npos - 4) / 34);
                last_clear = (e == 9'h001);
                last_rise  = cyc;
                npos++;
                watch    = 1'b1;
                stab_bad = 1'b0;
            end
            if (watch && ({lcd_rs, lcd_data} != cap)) stab_bad = 1'b1;
            if (!lcd_en && en_prev) begin
                check_eq("en_width", cyc - last_rise, T_PULSE);
                hold_left = T_HOLD;
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    check_eq("bus_stable", 32'(stab_bad), 0);
                    watch = 1'b0;
                end
            end
            if (init_done && !init_prev) begin
                check_eq("init_rise_pos", npos, 4);
                check_eq("init_rise_time", cyc - last_rise, T_PULSE + T_HOLD + T_EXEC);
            end
            if (frame_done && !fd_prev) begin
                check_eq("frame_at_end", 32'(npos > 4 && (npos - 4) % 34 == 0), 1);
                check_eq("frame_rise_time", cyc - last_rise, T_PULSE + T_HOLD + T_EXEC);
                frames_seen++;
                fd_rise = cyc;
            end
            if (!frame_done && fd_prev) check_eq("frame_width", cyc - fd_rise, 1);
            en_prev   = lcd_en;
            fd_prev   = frame_done;
            init_prev = init_done;
        end
    end

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames_seen < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_frames", 32'(frames_seen >= n), 1);
    endtask

    task automatic rand_table();
        for (int i = 0; i < 32; i++) tbl[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"},    32'(lcd_en), 0);
        check_eq({tag, "_rs"},    32'(lcd_rs), 0);
        check_eq({tag, "_data"},  32'(lcd_data), 0);
        check_eq({tag, "_index"}, 32'(lcd_index), 0);
        check_eq({tag, "_init"},  32'(init_done), 0);
        check_eq({tag, "_frame"}, 32'(frame_done), 0);
    endtask

    initial begin
        int target, k;
        reset_n = 1'b0;
        src_reg = 1'b0;
        for (int i = 0; i < 32; i++) tbl[i] = 8'(8'h40 + i);

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        check_eq("rst_on",   32'(lcd_on), 1);
        check_eq("rst_blon", 32'(lcd_blon), 1);
        check_eq("rst_rw",   32'(lcd_rw), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // init + frame with 0x40+index, combinational source
        wait_frames(1);
        // same contents through a registered source
        src_reg = 1'b1;
        wait_frames(2);
        // random contents and source latency per frame
        for (int f = 3; f <= 4; f++) begin
            rand_table();
            src_reg = 1'($urandom_range(0, 1));
            wait_frames(f);
        end

        // reset asserted asynchronously while EN is high mid-frame
        target = npos + int'($urandom_range(2, 20));
        k = 0;
        while (!(lcd_en && npos == target) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("reach_mid_frame", 32'(lcd_en && npos == target), 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rand_table();
        src_reg = 1'($urandom_range(0, 1));
        #2 reset_n = 1'b1;
        wait_frames(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
